// File: rtl/cim_temp_mem_if.sv
// Request/grant/response bundle between the CiM requestor FSMs and the
// temporary-result storage arbiter. Per-source fields are packed arrays.
interface cim_temp_mem_if #(
  parameter int NUM_SRC = 7,
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 10,
  parameter int SRC_W   = 3
);
  logic [NUM_SRC-1:0]             read_req;
  logic [NUM_SRC-1:0]             write_req;
  logic [NUM_SRC-1:0][ADDR_W-1:0] addr;
  logic [NUM_SRC-1:0][DATA_W-1:0] wr_data;
  logic [NUM_SRC-1:0]             rd_gnt;
  logic [NUM_SRC-1:0]             wr_gnt;
  logic                           rd_valid;
  logic [SRC_W-1:0]               rd_src;
  logic [DATA_W-1:0]              rd_data;
  logic                           addr_err;

  modport master (
    output read_req, write_req, addr, wr_data,
    input  rd_gnt, wr_gnt, rd_valid, rd_src, rd_data, addr_err
  );

  modport slave (
    input  read_req, write_req, addr, wr_data,
    output rd_gnt, wr_gnt, rd_valid, rd_src, rd_data, addr_err
  );
endinterface

// File: rtl/cim_temp_mem_arbiter.sv
// Per-CiM temporary-result storage with a round-robin arbiter in front.
// 2*NUM_SRC requestors (index 2s = write of source s, 2s+1 = read of s),
// one access per cycle, combinational grant, read data one cycle later.
module cim_temp_mem_arbiter #(
  parameter int NUM_SRC = 7,
  parameter int DATA_W  = 16,
  parameter int DEPTH   = 848,
  parameter int ADDR_W  = $clog2(DEPTH),
  parameter int SRC_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
)(
  input  logic           clk,
  input  logic           rst_n,
  cim_temp_mem_if.slave  bus
);
  localparam int NREQ  = 2 * NUM_SRC;
  localparam int PTR_W = $clog2(NREQ);

  logic [NREQ-1:0]    req;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W:0]     scan_idx;
  logic               gnt_any;
  logic [PTR_W-1:0]   gnt_idx;
  logic [SRC_W-1:0]   gnt_src;
  logic [NUM_SRC-1:0] rd_gnt_c, wr_gnt_c;
  logic               rd_fire, wr_fire;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;
  logic               in_range;

  logic [DATA_W-1:0]  mem [DEPTH];
  logic               rd_vld_q;
  logic [SRC_W-1:0]   rd_src_q;
  logic [DATA_W-1:0]  rd_data_q;
  logic               addr_err_q;

  // Interleave write/read requests so each source owns two adjacent RR slots.
  for (genvar s = 0; s < NUM_SRC; s++) begin : g_req
    assign req[2*s]   = bus.write_req[s];
    assign req[2*s+1] = bus.read_req[s];
  end

  // RR scan: walk offsets high to low so the smallest offset from ptr wins.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    scan_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      scan_idx = {1'b0, ptr} + (PTR_W+1)'(k);
      if (scan_idx >= (PTR_W+1)'(NREQ))
        scan_idx = scan_idx - (PTR_W+1)'(NREQ);
      if (req[scan_idx[PTR_W-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = scan_idx[PTR_W-1:0];
      end
    end
  end

  assign gnt_src  = gnt_idx[PTR_W-1:1];
  assign sel_addr = bus.addr[gnt_src];
  assign sel_data = bus.wr_data[gnt_src];
  assign in_range = {1'b0, sel_addr} < (ADDR_W+1)'(DEPTH);

  // Decode winner into one-hot grants; nothing is granted while in reset.
  always_comb begin
    rd_gnt_c = '0;
    wr_gnt_c = '0;
    if (gnt_any && rst_n) begin
      if (gnt_idx[0]) rd_gnt_c[gnt_src] = 1'b1;
      else            wr_gnt_c[gnt_src] = 1'b1;
    end
  end

  assign rd_fire = |rd_gnt_c;
  assign wr_fire = |wr_gnt_c;

  // Storage write; out-of-range writes are dropped. Contents are not reset.
  always_ff @(posedge clk) begin
    if (wr_fire && in_range) mem[sel_addr] <= sel_data;
  end

  // Pointer, read response and sticky error; reset also kills an in-flight read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr        <= '0;
      rd_vld_q   <= 1'b0;
      rd_src_q   <= '0;
      rd_data_q  <= '0;
      addr_err_q <= 1'b0;
    end else begin
      if (gnt_any)
        ptr <= (gnt_idx == PTR_W'(NREQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
      rd_vld_q <= rd_fire;
      if (rd_fire) begin
        rd_src_q  <= gnt_src;
        rd_data_q <= in_range ? mem[sel_addr] : '0;
      end
      if ((rd_fire || wr_fire) && !in_range) addr_err_q <= 1'b1;
    end
  end

  assign bus.rd_gnt   = rd_gnt_c;
  assign bus.wr_gnt   = wr_gnt_c;
  assign bus.rd_valid = rd_vld_q;
  assign bus.rd_src   = rd_src_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.addr_err = addr_err_q;
endmodule

// File: tb/tb_cim_temp_mem_arbiter.sv
// Directed bench for cim_temp_mem_arbiter. Stimulus checks grants against
// hand-picked winner indices and pushes expected read responses; a separate
// monitor pops and checks them whenever rd_valid is seen.
module tb_cim_temp_mem_arbiter;
  localparam int NUM_SRC = 7;
  localparam int DATA_W  = 16;
  localparam int DEPTH   = 848;
  localparam int ADDR_W  = 10;
  localparam int SRC_W   = 3;

  typedef struct {
    logic [SRC_W-1:0]  src;
    logic [DATA_W-1:0] data;
    bit                known;
    int                due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cim_temp_mem_if #(.NUM_SRC(NUM_SRC), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .SRC_W(SRC_W)) bus();

  cim_temp_mem_arbiter #(.NUM_SRC(NUM_SRC), .DATA_W(DATA_W), .DEPTH(DEPTH),
                         .ADDR_W(ADDR_W), .SRC_W(SRC_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc_cnt = 0;
  exp_t exp_q[$];
  exp_t me;

  logic [DATA_W-1:0] mem_m [DEPTH];
  bit                mem_k [DEPTH];
  bit                err_m;

  logic [NUM_SRC-1:0] rr, wr;
  logic [ADDR_W-1:0]  a_tab [NUM_SRC];
  logic [DATA_W-1:0]  d_tab [NUM_SRC];
  int                 last_gnt;
  int                 cnt [2*NUM_SRC];

  always @(posedge clk) cyc_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  task automatic drive();
    bus.read_req  = rr;
    bus.write_req = wr;
    for (int s = 0; s < NUM_SRC; s++) begin
      bus.addr[s]    = a_tab[s];
      bus.wr_data[s] = d_tab[s];
    end
  endtask

  // One cycle: drive, check grants against the expected winner, update model.
  task automatic cyc(input int exp_idx);
    logic [NUM_SRC-1:0] er, ew;
    logic [ADDR_W-1:0]  a;
    int                 s;
    exp_t               e;
    drive();
    @(negedge clk);
    er = '0;
    ew = '0;
    s  = (exp_idx >= 0) ? exp_idx / 2 : 0;
    if (exp_idx >= 0) begin
      if (exp_idx % 2 == 1) er[s] = 1'b1;
      else                  ew[s] = 1'b1;
    end
    chk("rd_gnt", 32'(bus.rd_gnt), 32'(er));
    chk("wr_gnt", 32'(bus.wr_gnt), 32'(ew));
    chk("addr_err", 32'(bus.addr_err), 32'(err_m));
    last_gnt = -1;
    for (int j = 0; j < NUM_SRC; j++) begin
      if (bus.wr_gnt[j]) last_gnt = 2*j;
      if (bus.rd_gnt[j]) last_gnt = 2*j + 1;
    end
    if (exp_idx >= 0) begin
      a = a_tab[s];
      if (exp_idx % 2 == 0) begin
        if (int'(a) < DEPTH) begin
          mem_m[a] = d_tab[s];
          mem_k[a] = 1'b1;
        end else err_m = 1'b1;
      end else begin
        e.src = SRC_W'(s);
        e.due = cyc_cnt + 1;
        if (int'(a) < DEPTH) begin
          e.data  = mem_m[a];
          e.known = mem_k[a];
        end else begin
          e.data  = '0;
          e.known = 1'b1;
          err_m   = 1'b1;
        end
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rr = '0;
    wr = '0;
    drive();
    @(negedge clk);
    #1 rst_n = 1'b0;
    err_m = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Response monitor: every rd_valid must match the oldest expectation, on time.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.rd_valid) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL rd_unexpected: got rd_valid=1 src=%0d, expected none", bus.rd_src);
        end else begin
          me = exp_q.pop_front();
          chk("rd_latency", 32'(cyc_cnt), 32'(me.due));
          chk("rd_src", 32'(bus.rd_src), 32'(me.src));
          if (me.known) chk("rd_data", 32'(bus.rd_data), 32'(me.data));
        end
      end else if (exp_q.size() != 0 && exp_q[0].due <= cyc_cnt) begin
        n_chk++;
        n_fail++;
        $display("FAIL rd_missing: got rd_valid=0, expected response for src %0d", exp_q[0].src);
        me = exp_q.pop_front();
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b1;
    err_m = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      a_tab[s] = '0;
      d_tab[s] = '0;
    end
    rr = '1;
    wr = '1;
    drive();
    #2 rst_n = 1'b0;

    // 1: requests during reset give nothing; read killed by async reset.
    repeat (2) @(negedge clk);
    chk("rst_rd_gnt", 32'(bus.rd_gnt), 32'd0);
    chk("rst_wr_gnt", 32'(bus.wr_gnt), 32'd0);
    chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("rst_rd_src", 32'(bus.rd_src), 32'd0);
    chk("rst_rd_data", 32'(bus.rd_data), 32'd0);
    chk("rst_addr_err", 32'(bus.addr_err), 32'd0);
    #1;
    rr = '0;
    wr = '0;
    drive();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rr = 7'b0100000;
    drive();
    @(negedge clk);
    chk("kill_rd_gnt", 32'(bus.rd_gnt), 32'h20);
    @(posedge clk);
    #1 rst_n = 1'b0;
    rr = '0;
    drive();
    @(negedge clk);
    chk("kill_rd_valid_in_rst", 32'(bus.rd_valid), 32'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("kill_rd_valid_after", 32'(bus.rd_valid), 32'd0);
    @(posedge clk);
    #1;

    // 2: LOGIC_FSM write 0x1234 @5 then read it back.
    a_tab[1] = 10'd5;
    d_tab[1] = 16'h1234;
    wr = 7'b0000010; rr = '0;
    cyc(2);
    wr = '0; rr = 7'b0000010;
    cyc(3);
    rr = '0;
    cyc(-1);
    cyc(-1);
    @(negedge clk);
    chk("hold_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("hold_rd_data", 32'(bus.rd_data), 32'h1234);
    @(posedge clk);
    #1;

    // 3: MAC/LN/SM contention from ptr=0, then prove ptr wrapped to 0.
    apply_reset();
    wr = 7'b0010000;
    a_tab[4] = 10'd10; d_tab[4] = 16'hAAAA; cyc(8);
    a_tab[4] = 10'd11; d_tab[4] = 16'hBBBB; cyc(8);
    a_tab[4] = 10'd12; d_tab[4] = 16'hCCCC; cyc(8);
    apply_reset();
    a_tab[4] = 10'd10; a_tab[5] = 10'd11; a_tab[6] = 10'd12;
    rr = 7'b1110000;
    cyc(9);
    rr = 7'b1100000;
    cyc(11);
    rr = 7'b1000000;
    cyc(13);
    a_tab[0] = 10'd30; d_tab[0] = 16'h5555;
    wr = 7'b0000001;
    cyc(0);
    wr = '0;
    cyc(13);
    rr = '0;
    cyc(-1);

    // 4: all 14 requestors held, two full rotations.
    apply_reset();
    for (int s = 0; s < NUM_SRC; s++) begin
      a_tab[s] = ADDR_W'(100 + s);
      d_tab[s] = 16'h4000 + DATA_W'(s);
    end
    rr = '1;
    wr = '1;
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 2*NUM_SRC; i++) cnt[i] = 0;
      for (int k = 0; k < 2*NUM_SRC; k++) begin
        cyc(k);
        if (last_gnt >= 0) cnt[last_gnt]++;
      end
      for (int i = 0; i < 2*NUM_SRC; i++) chk("fair_cnt", 32'(cnt[i]), 32'd1);
    end
    rr = '0;
    wr = '0;
    cyc(-1);

    // 5: same-source read+write @20, ptr=0 (write first) then ptr=1 (read first).
    apply_reset();
    a_tab[0] = 10'd20; d_tab[0] = 16'h0001;
    wr = 7'b0000001;
    cyc(0);
    wr = '0;
    apply_reset();
    d_tab[0] = 16'hBEEF;
    wr = 7'b0000001; rr = 7'b0000001;
    cyc(0);
    wr = '0;
    cyc(1);
    rr = '0;
    cyc(-1);
    d_tab[0] = 16'h0001;
    wr = 7'b0000001;
    cyc(0);
    d_tab[0] = 16'hBEEF;
    rr = 7'b0000001;
    cyc(1);
    rr = '0;
    cyc(0);
    wr = '0;
    cyc(-1);
    rr = 7'b0000001;
    cyc(1);
    rr = '0;
    cyc(-1);

    // 6: out-of-range write/read from BUS_FSM, full-memory integrity check.
    apply_reset();
    wr = 7'b0000100;
    for (int i = 0; i < DEPTH; i++) begin
      a_tab[2] = ADDR_W'(i);
      d_tab[2] = DATA_W'(i * 37) ^ 16'hA5A5;
      cyc(4);
    end
    wr = 7'b0000001;
    a_tab[0] = ADDR_W'(DEPTH);
    d_tab[0] = 16'hDEAD;
    cyc(0);
    wr = '0;
    rr = 7'b0000001;
    a_tab[0] = ADDR_W'(DEPTH + 3);
    cyc(1);
    rr = '0;
    cyc(-1);
    rr = 7'b0001000;
    for (int i = 0; i < DEPTH; i++) begin
      a_tab[3] = ADDR_W'(i);
      cyc(7);
    end
    rr = '0;
    cyc(-1);
    cyc(-1);
    @(negedge clk);
    chk("addr_err_sticky", 32'(bus.addr_err), 32'd1);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
